// File: rtl/mem_write_scoreboard.sv
// Memory-write scoreboard: checks processor data-memory writes against a loaded table of
// expected (address, data) pairs. Define MEM_WRITE_SCOREBOARD_TIMEOUT_EN to add the ARMED-state timeout.
module mem_write_scoreboard #(
    parameter int                 WIDTH       = 32,
    parameter int                 DEPTH       = 4,
    parameter logic [WIDTH-1:0]   IGNORE_ADDR = WIDTH'(80),
    parameter int                 TIMEOUT     = 4096,
    localparam int                IDXW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDXW:0]    num_exp,
    input  logic             ld_en,
    input  logic [IDXW-1:0]  ld_idx,
    input  logic [WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [IDXW:0]    match_cnt,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PASS = 2'd2, FAIL = 2'd3} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  exp_addr_reg [DEPTH];
    logic [WIDTH-1:0]  exp_data_reg [DEPTH];
    logic [IDXW-1:0]   idx_reg;
    logic [IDXW:0]     num_exp_reg;
    logic [IDXW:0]     match_cnt_reg;
    logic [1:0]        fail_code_reg;
    logic [WIDTH-1:0]  fail_addr_reg;
    logic [WIDTH-1:0]  fail_data_reg;

    logic num_ok, wr_event, hit, final_hit, miss, timeout;

    assign num_ok    = (num_exp != '0) && (num_exp <= (IDXW+1)'(DEPTH));
    assign wr_event  = (state_reg == ARMED) && memwrite && (dataadr != IGNORE_ADDR);
    assign hit       = (dataadr == exp_addr_reg[idx_reg]) && (writedata == exp_data_reg[idx_reg]);
    assign final_hit = wr_event && hit && ((match_cnt_reg + 1'b1) == num_exp_reg);
    assign miss      = wr_event && !hit;

`ifdef MEM_WRITE_SCOREBOARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] timer_reg;

    assign timeout = (state_reg == ARMED) && (timer_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer_reg <= '0;
        else if (state_reg != ARMED)
            timer_reg <= '0;
        else
            timer_reg <= timer_reg + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // A final match beats a simultaneous timeout; a mismatch beats it too.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ARMED) begin
            if (final_hit)
                state_next = PASS;
            else if (miss || timeout)
                state_next = FAIL;
        end else if (start) begin
            state_next = num_ok ? ARMED : FAIL;
        end
    end

    always_comb begin
        busy = (state_reg == ARMED);
        pass = (state_reg == PASS);
        fail = (state_reg == FAIL);
    end

    // The table is only writable outside a run, so an armed check sees a stable table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_addr_reg[i] <= '0;
                exp_data_reg[i] <= '0;
            end
        end else if (ld_en && (state_reg != ARMED)) begin
            exp_addr_reg[ld_idx] <= ld_addr;
            exp_data_reg[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg       <= '0;
            num_exp_reg   <= '0;
            match_cnt_reg <= '0;
            fail_code_reg <= 2'd0;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
        end else if (state_reg != ARMED) begin
            if (start) begin
                idx_reg       <= '0;
                num_exp_reg   <= num_exp;
                match_cnt_reg <= '0;
                fail_code_reg <= num_ok ? 2'd0 : 2'd3;
                fail_addr_reg <= '0;
                fail_data_reg <= '0;
            end
        end else if (wr_event && hit) begin
            match_cnt_reg <= match_cnt_reg + 1'b1;
            if (!final_hit)
                idx_reg <= idx_reg + 1'b1;
        end else if (miss) begin
            fail_code_reg <= 2'd1;
            fail_addr_reg <= dataadr;
            fail_data_reg <= writedata;
        end else if (timeout) begin
            fail_code_reg <= 2'd2;
        end
    end

    assign match_cnt = match_cnt_reg;
    assign fail_code = fail_code_reg;
    assign fail_addr = fail_addr_reg;
    assign fail_data = fail_data_reg;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Directed bench for mem_write_scoreboard (DEPTH 4, TIMEOUT 16); timeout checks follow
// MEM_WRITE_SCOREBOARD_TIMEOUT_EN.
module tb_mem_write_scoreboard;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int IDXW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [IDXW:0]    num_exp = '0;
    logic             ld_en = 1'b0;
    logic [IDXW-1:0]  ld_idx = '0;
    logic [WIDTH-1:0] ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    logic             memwrite = 1'b0;
    logic [WIDTH-1:0] dataadr = '0;
    logic [WIDTH-1:0] writedata = '0;
    logic             busy, pass, fail;
    logic [1:0]       fail_code;
    logic [IDXW:0]    match_cnt;
    logic [WIDTH-1:0] fail_addr, fail_data;

    int checks = 0;
    int failures = 0;

    mem_write_scoreboard #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IGNORE_ADDR(32'd80), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_data(ld_data),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int a, input int d);
        ld_en = 1'b1; ld_idx = IDXW'(idx); ld_addr = WIDTH'(a); ld_data = WIDTH'(d);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic arm(input int n);
        num_exp = (IDXW+1)'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        memwrite = 1'b1; dataadr = WIDTH'(a); writedata = WIDTH'(d);
        tick();
        memwrite = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, ".busy"}, 64'(busy), 0);
        check({pfx, ".pass"}, 64'(pass), 0);
        check({pfx, ".fail"}, 64'(fail), 0);
        check({pfx, ".fail_code"}, 64'(fail_code), 0);
        check({pfx, ".match_cnt"}, 64'(match_cnt), 0);
        check({pfx, ".fail_addr"}, 64'(fail_addr), 0);
        check({pfx, ".fail_data"}, 64'(fail_data), 0);
    endtask

    initial begin
        int cnt;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // single expected write, scratch address skipped
        load(0, 84, 7);
        arm(1);
        check("t1.busy_after_start", 64'(busy), 1);
        wr(80, 3);
        check("t1.ignored_busy", 64'(busy), 1);
        check("t1.ignored_pass", 64'(pass), 0);
        wr(84, 7);
        check("t1.pass", 64'(pass), 1);
        check("t1.match_cnt", 64'(match_cnt), 1);
        check("t1.fail_code", 64'(fail_code), 0);
        check("t1.busy", 64'(busy), 0);

        // three writes with idle gaps
        load(0, 0, 5); load(1, 4, 9); load(2, 8, 12);
        arm(3);
        wr(0, 5); tick();
        wr(4, 9); tick(); tick();
        check("t2.mid_match_cnt", 64'(match_cnt), 2);
        check("t2.mid_busy", 64'(busy), 1);
        wr(8, 12);
        check("t2.pass", 64'(pass), 1);
        check("t2.match_cnt", 64'(match_cnt), 3);
        wr(0, 99);
        check("t2.extra_pass", 64'(pass), 1);
        check("t2.extra_fail", 64'(fail), 0);
        check("t2.extra_match_cnt", 64'(match_cnt), 3);

        // mismatch on second write, back to back
        arm(3);
        wr(0, 5);
        wr(4, 10);
        check("t3.fail", 64'(fail), 1);
        check("t3.fail_code", 64'(fail_code), 1);
        check("t3.fail_addr", 64'(fail_addr), 4);
        check("t3.fail_data", 64'(fail_data), 10);
        check("t3.match_cnt", 64'(match_cnt), 1);

        // no writes at all
        arm(1);
        check("t4.busy", 64'(busy), 1);
`ifdef MEM_WRITE_SCOREBOARD_TIMEOUT_EN
        cnt = 0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("t4.timeout_cycles", 64'(cnt), 16);
        check("t4.fail", 64'(fail), 1);
        check("t4.fail_code", 64'(fail_code), 2);
`else
        cnt = 0;
        repeat (100) tick();
        check("t4.still_busy", 64'(busy), 1);
        check("t4.no_fail", 64'(fail), 0);
        wr(0, 5);
        check("t4.pass", 64'(pass), 1);
`endif

        // bad num_exp values
        arm(0);
        check("t5.zero_busy", 64'(busy), 0);
        check("t5.zero_fail", 64'(fail), 1);
        check("t5.zero_code", 64'(fail_code), 3);
        arm(DEPTH + 1);
        check("t5.over_busy", 64'(busy), 0);
        check("t5.over_fail", 64'(fail), 1);
        check("t5.over_code", 64'(fail_code), 3);

        // table load in the same cycle as start is used by that run
        ld_en = 1'b1; ld_idx = '0; ld_addr = 32'd20; ld_data = 32'd1;
        arm(1);
        ld_en = 1'b0;
        wr(20, 1);
        check("t6.same_cycle_load_pass", 64'(pass), 1);

        // asynchronous reset mid-run
        load(0, 0, 5);
        arm(3);
        wr(0, 5);
        check("t7.pre_reset_match_cnt", 64'(match_cnt), 1);
        #3 reset = 1'b1;
        #1 check_all_zero("t7.async_reset");
        @(posedge clk); #1 reset = 1'b0;
        load(0, 0, 5); load(1, 4, 9); load(2, 8, 12);
        arm(3);
        wr(0, 5); wr(4, 9); wr(8, 12);
        check("t7.rearm_pass", 64'(pass), 1);
        check("t7.rearm_match_cnt", 64'(match_cnt), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
